// File: rtl/mmio_pkg.sv
// Shared types, register offsets and default tag map for the MMIO bridge.
package mmio_pkg;

    typedef enum logic [2:0] {
        MEMOP_B  = 3'b000,
        MEMOP_H  = 3'b001,
        MEMOP_W  = 3'b010,
        MEMOP_BU = 3'b100,
        MEMOP_HU = 3'b101
    } memop_e;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_UNMAPPED_RD = 3'd1,
        ERR_UNMAPPED_WR = 3'd2,
        ERR_MISALIGNED  = 3'd3
    } err_type_e;

    localparam int unsigned TMR_US_OFF   = 32'h0;
    localparam int unsigned TMR_MS_OFF   = 32'h4;
    localparam int unsigned TMR_S_OFF    = 32'h8;
    localparam int unsigned TMR_CLR_OFF  = 32'hC;
    localparam int unsigned ERR_STAT_OFF = 32'h0;
    localparam int unsigned ERR_ADDR_OFF = 32'h4;

    // Channel i answers to tag i+1; channel 0 sits in the LSBs.
    localparam logic [47:0] DEF_CH_TAGS = {12'h004, 12'h003, 12'h002, 12'h001};
    localparam logic [11:0] DEF_TMR_TAG = 12'h00A;
    localparam logic [11:0] DEF_ERR_TAG = 12'h00F;

    // Bring the addressed lane down to bit 0 and extend it per load type.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  op);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (op)
            MEMOP_B:  extend_load = {{24{sh[7]}}, sh[7:0]};
            MEMOP_BU: extend_load = {24'h0, sh[7:0]};
            MEMOP_H:  extend_load = {{16{sh[15]}}, sh[15:0]};
            MEMOP_HU: extend_load = {16'h0, sh[15:0]};
            MEMOP_W:  extend_load = sh;
            default:  extend_load = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running microsecond / millisecond / second counters with a ms pulse.
module mmio_timer #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    output logic [31:0] us,
    output logic [31:0] ms,
    output logic [31:0] s,
    output logic        ms_tick
);
    localparam int unsigned PRESC   = CLK_HZ / 1_000_000;
    localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [9:0]         us_sub_q, us_sub_d, ms_sub_q, ms_sub_d;
    logic [31:0]        us_q, us_d, ms_q, ms_d, s_q, s_d;
    logic               tick_q, tick_d;
    logic               us_inc, ms_inc, s_inc;

    // Sub-counters carry the cascade so the 32-bit counters can wrap freely.
    always_comb begin
        us_inc   = (presc_q == PRESC_W'(PRESC - 1));
        ms_inc   = us_inc && (us_sub_q == 10'd999);
        s_inc    = ms_inc && (ms_sub_q == 10'd999);
        presc_d  = presc_q;
        us_sub_d = us_sub_q;
        ms_sub_d = ms_sub_q;
        us_d     = us_q;
        ms_d     = ms_q;
        s_d      = s_q;
        tick_d   = 1'b0;
        if (clr) begin
            presc_d  = '0;
            us_sub_d = '0;
            ms_sub_d = '0;
            us_d     = '0;
            ms_d     = '0;
            s_d      = '0;
        end else begin
            presc_d = us_inc ? '0 : presc_q + PRESC_W'(1);
            tick_d  = ms_inc;
            if (us_inc) begin
                us_d     = us_q + 32'd1;
                us_sub_d = ms_inc ? 10'd0 : us_sub_q + 10'd1;
            end
            if (ms_inc) begin
                ms_d     = ms_q + 32'd1;
                ms_sub_d = s_inc ? 10'd0 : ms_sub_q + 10'd1;
            end
            if (s_inc) begin
                s_d = s_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q  <= '0;
            us_sub_q <= '0;
            ms_sub_q <= '0;
            us_q     <= '0;
            ms_q     <= '0;
            s_q      <= '0;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            us_sub_q <= us_sub_d;
            ms_sub_q <= ms_sub_d;
            us_q     <= us_d;
            ms_q     <= ms_d;
            s_q      <= s_d;
            tick_q   <= tick_d;
        end
    end

    assign us      = us_q;
    assign ms      = ms_q;
    assign s       = s_q;
    assign ms_tick = tick_q;

endmodule

// File: rtl/mmio_bridge.sv
// CPU data-port to peripheral bridge: tag decode, lane strobes, load
// extension, internal timer bank and sticky error-capture register.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned               NUM_CH  = 4,
    parameter int unsigned               TAG_W   = 12,
    parameter logic [NUM_CH*TAG_W-1:0]   CH_TAGS = DEF_CH_TAGS,
    parameter logic [TAG_W-1:0]          TMR_TAG = DEF_TMR_TAG,
    parameter logic [TAG_W-1:0]          ERR_TAG = DEF_ERR_TAG,
    parameter int unsigned               CLK_HZ  = 50_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic [2:0]             cpu_memop,
    input  logic                   cpu_we,
    input  logic                   cpu_re,
    output logic [31:0]            cpu_rdata,
    output logic [NUM_CH-1:0]      ch_sel,
    output logic [NUM_CH-1:0]      ch_we,
    output logic [3:0]             ch_be,
    output logic [31-TAG_W:0]      ch_addr,
    output logic [31:0]            ch_wdata,
    input  logic [NUM_CH*32-1:0]   ch_rdata,
    output logic                   ms_tick,
    output logic                   err_pending
);
    localparam int unsigned OFF_W = 32 - TAG_W;

    logic [TAG_W-1:0]  tag;
    logic [OFF_W-1:0]  off, woff;
    logic [NUM_CH-1:0] ch_hit;
    logic              ch_found, tmr_hit, err_hit, unmapped;
    logic              aligned;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic              tmr_clr, err_clr;
    logic [31:0]       tmr_us, tmr_ms, tmr_s;
    logic [31:0]       rd_word;
    err_type_e         fault;

    logic [31:0] rdata_q, rdata_d;
    logic        err_pend_q, err_pend_d;
    err_type_e   err_type_q, err_type_d;
    logic [31:0] err_addr_q, err_addr_d;

    assign tag  = cpu_addr[31:OFF_W];
    assign off  = cpu_addr[OFF_W-1:0];
    assign woff = {off[OFF_W-1:2], 2'b00};

    // Region decode; lowest channel index wins on duplicate tags.
    always_comb begin
        ch_hit   = '0;
        ch_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!ch_found && tag == CH_TAGS[i*TAG_W +: TAG_W]) begin
                ch_hit[i] = 1'b1;
                ch_found  = 1'b1;
            end
        end
        tmr_hit  = !ch_found && (tag == TMR_TAG);
        err_hit  = !ch_found && !tmr_hit && (tag == ERR_TAG);
        unmapped = !ch_found && !tmr_hit && !err_hit;
    end

    // Alignment, byte enables and lane replication of store data.
    always_comb begin
        aligned   = 1'b0;
        be        = 4'b0000;
        wdata_rep = cpu_wdata;
        case (cpu_memop)
            MEMOP_B, MEMOP_BU: begin
                aligned   = 1'b1;
                be        = 4'b0001 << cpu_addr[1:0];
                wdata_rep = {4{cpu_wdata[7:0]}};
            end
            MEMOP_H, MEMOP_HU: begin
                aligned   = !cpu_addr[0];
                be        = aligned ? (4'b0011 << cpu_addr[1:0]) : 4'b0000;
                wdata_rep = {2{cpu_wdata[15:0]}};
            end
            MEMOP_W: begin
                aligned = (cpu_addr[1:0] == 2'b00);
                be      = aligned ? 4'b1111 : 4'b0000;
            end
            default: ;
        endcase
    end

    assign ch_sel   = ch_hit;
    assign ch_we    = ch_hit & {NUM_CH{cpu_we & aligned}};
    assign ch_be    = be;
    assign ch_addr  = off;
    assign ch_wdata = wdata_rep;

    assign tmr_clr = cpu_we && aligned && tmr_hit && (woff == OFF_W'(TMR_CLR_OFF));
    assign err_clr = cpu_we && aligned && err_hit && (woff == OFF_W'(ERR_STAT_OFF));

    mmio_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (tmr_clr),
        .us      (tmr_us),
        .ms      (tmr_ms),
        .s       (tmr_s),
        .ms_tick (ms_tick)
    );

    // Load path: pick the region word, then extend; internal reads see pre-write state.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) rd_word = rd_word | ch_rdata[i*32 +: 32];
        end
        if (tmr_hit) begin
            if (woff == OFF_W'(TMR_US_OFF))      rd_word = tmr_us;
            else if (woff == OFF_W'(TMR_MS_OFF)) rd_word = tmr_ms;
            else if (woff == OFF_W'(TMR_S_OFF))  rd_word = tmr_s;
        end
        if (err_hit) begin
            if (woff == OFF_W'(ERR_STAT_OFF))      rd_word = {err_pend_q, 28'h0, err_type_q};
            else if (woff == OFF_W'(ERR_ADDR_OFF)) rd_word = err_addr_q;
        end
        rdata_d = rdata_q;
        if (cpu_re) rdata_d = aligned ? extend_load(rd_word, cpu_addr[1:0], cpu_memop) : 32'h0;
    end

    // First error is sticky; a fault coinciding with a clear replaces it.
    always_comb begin
        fault = ERR_NONE;
        if (cpu_re || cpu_we) begin
            if (!aligned)     fault = ERR_MISALIGNED;
            else if (unmapped) fault = cpu_re ? ERR_UNMAPPED_RD : ERR_UNMAPPED_WR;
        end
        err_pend_d = err_pend_q;
        err_type_d = err_type_q;
        err_addr_d = err_addr_q;
        if (fault != ERR_NONE && (!err_pend_q || err_clr)) begin
            err_pend_d = 1'b1;
            err_type_d = fault;
            err_addr_d = cpu_addr;
        end else if (err_clr) begin
            err_pend_d = 1'b0;
            err_type_d = ERR_NONE;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q    <= '0;
            err_pend_q <= 1'b0;
            err_type_q <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            rdata_q    <= rdata_d;
            err_pend_q <= err_pend_d;
            err_type_q <= err_type_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign cpu_rdata   = rdata_q;
    assign err_pending = err_pend_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: directed scenarios plus random traffic
// checked against an elapsed-time / region-level reference model.
module tb_mmio_bridge;

    localparam int unsigned NCH    = 4;
    localparam int unsigned CYC_MS = 2000;   // 2 MHz clock

    logic             clock;
    logic             reset;
    logic [31:0]      cpu_addr, cpu_wdata, cpu_rdata, ch_wdata;
    logic [2:0]       cpu_memop;
    logic             cpu_we, cpu_re, ms_tick, err_pending;
    logic [NCH-1:0]   ch_sel, ch_we;
    logic [3:0]       ch_be;
    logic [19:0]      ch_addr;
    logic [NCH*32-1:0] ch_rdata;

    mmio_bridge #(
        .NUM_CH (4),
        .CLK_HZ (2_000_000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_memop   (cpu_memop),
        .cpu_we      (cpu_we),
        .cpu_re      (cpu_re),
        .cpu_rdata   (cpu_rdata),
        .ch_sel      (ch_sel),
        .ch_we       (ch_we),
        .ch_be       (ch_be),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_rdata    (ch_rdata),
        .ms_tick     (ms_tick),
        .err_pending (err_pending)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] exp;
    } item_t;

    item_t       sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    // reference model state
    bit          m_pend;
    logic [2:0]  m_type;
    logic [31:0] m_eaddr;
    logic [31:0] m_rdata;
    int unsigned m_t;          // counting edges since reset / timer clear
    logic [31:0] chr [NCH];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0: kname = "strobes";
            1: kname = "cpu_rdata";
            2: kname = "err_pending";
            default: kname = "ms_tick";
        endcase
    endfunction

    // 0..3 channel, 4 timer, 5 error, 6 unmapped
    function automatic int region(input logic [31:0] a);
        logic [11:0] t;
        t = a[31:20];
        if (t >= 12'h001 && t <= 12'h004) region = int'(t) - 1;
        else if (t == 12'h00A)            region = 4;
        else if (t == 12'h00F)            region = 5;
        else                              region = 6;
    endfunction

    function automatic bit access_ok(input logic [31:0] a, input logic [2:0] mo);
        case (mo)
            3'd0, 3'd4: access_ok = 1'b1;
            3'd1, 3'd5: access_ok = (a[0] == 1'b0);
            3'd2:       access_ok = (a[1:0] == 2'b00);
            default:    access_ok = 1'b0;
        endcase
    endfunction

    task automatic push(input int c, input int k, input logic [63:0] e);
        item_t it;
        it.cyc  = c;
        it.kind = k;
        it.exp  = e;
        sbq.push_back(it);
    endtask

    // One bus cycle: drive inputs, predict outputs, advance the model.
    task automatic step(input bit rst, input bit re, input bit we,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] mo);
        int          rg;
        bit          ok, tick;
        logic [3:0]  sel, wes, be;
        logic [31:0] wdx, word, sh, ext;
        logic [19:0] woff;
        logic [2:0]  fault;
        bit          clr_e, clr_t;
        @(posedge clock);
        #1;
        reset     = rst;
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_memop = mo;
        ch_rdata  = {chr[3], chr[2], chr[1], chr[0]};

        rg  = region(a);
        ok  = access_ok(a, mo);
        sel = (rg < 4) ? (4'b0001 << rg) : 4'b0000;
        wes = (we && ok) ? sel : 4'b0000;
        be  = 4'b0000;
        if (ok) begin
            if (mo == 3'd0 || mo == 3'd4)      be = 4'b0001 << a[1:0];
            else if (mo == 3'd1 || mo == 3'd5) be = 4'b0011 << a[1:0];
            else                               be = 4'b1111;
        end
        if (mo == 3'd0 || mo == 3'd4)      wdx = {4{wd[7:0]}};
        else if (mo == 3'd1 || mo == 3'd5) wdx = {2{wd[15:0]}};
        else                               wdx = wd;
        push(cyc, 0, {sel, wes, be, a[19:0], wdx});

        woff = a[19:0] & 20'hFFFFC;
        word = 32'h0;
        if (rg < 4) word = chr[rg];
        else if (rg == 4) begin
            if (woff == 20'h0)      word = 32'(m_t / 2);
            else if (woff == 20'h4) word = 32'(m_t / CYC_MS);
            else if (woff == 20'h8) word = 32'(m_t / (CYC_MS * 1000));
        end else if (rg == 5) begin
            if (woff == 20'h0)      word = {m_pend, 28'h0, m_type};
            else if (woff == 20'h4) word = m_eaddr;
        end
        sh = word >> (8 * int'(a[1:0]));
        case (mo)
            3'd0: begin ext = sh & 32'hFF;   if (ext[7])  ext = ext | 32'hFFFFFF00; end
            3'd4: ext = sh & 32'hFF;
            3'd1: begin ext = sh & 32'hFFFF; if (ext[15]) ext = ext | 32'hFFFF0000; end
            3'd5: ext = sh & 32'hFFFF;
            default: ext = sh;
        endcase

        if (rst) begin
            m_rdata = 32'h0;
            m_pend  = 1'b0;
            m_type  = 3'd0;
            m_eaddr = 32'h0;
            m_t     = 0;
        end else begin
            if (re) m_rdata = ok ? ext : 32'h0;
            fault = 3'd0;
            if (re || we) begin
                if (!ok)         fault = 3'd3;
                else if (rg == 6) fault = re ? 3'd1 : 3'd2;
            end
            clr_e = we && ok && rg == 5 && woff == 20'h0;
            clr_t = we && ok && rg == 4 && woff == 20'hC;
            if (fault != 3'd0 && (!m_pend || clr_e)) begin
                m_pend  = 1'b1;
                m_type  = fault;
                m_eaddr = a;
            end else if (clr_e) begin
                m_pend  = 1'b0;
                m_type  = 3'd0;
                m_eaddr = 32'h0;
            end
            m_t = clr_t ? 0 : m_t + 1;
        end
        tick = !rst && m_t != 0 && (m_t % CYC_MS) == 0;
        push(cyc + 1, 1, 64'(m_rdata));
        push(cyc + 1, 2, 64'(m_pend));
        push(cyc + 1, 3, 64'(tick));
    endtask

    // Monitor: compare every prediction due in this cycle.
    item_t       mon_it;
    logic [63:0] mon_act;
    always @(negedge clock) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_it = sbq.pop_front();
            case (mon_it.kind)
                0: mon_act = {ch_sel, ch_we, ch_be, ch_addr, ch_wdata};
                1: mon_act = 64'(cpu_rdata);
                2: mon_act = 64'(err_pending);
                default: mon_act = 64'(ms_tick);
            endcase
            checks = checks + 1;
            if (mon_act !== mon_it.exp || mon_it.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d due=%0d got=%h want=%h",
                         kname(mon_it.kind), cyc, mon_it.cyc, mon_act, mon_it.exp);
            end
        end
    end

    initial begin
        logic [11:0] tg;
        logic [19:0] of;
        int          rs;
        reset     = 1'b1;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_memop = 3'd0;
        ch_rdata  = '0;
        m_pend    = 1'b0;
        m_type    = 3'd0;
        m_eaddr   = 32'h0;
        m_rdata   = 32'h0;
        m_t       = 0;
        for (int i = 0; i < NCH; i++) chr[i] = 32'h0;

        repeat (3) step(1, 0, 0, 32'h0, 32'h0, 3'd0);

        // store half to channel 1, then signed/unsigned sub-word loads from channel 2
        step(0, 0, 1, 32'h0020_0006, 32'h0000_BEEF, 3'd1);
        chr[2] = 32'h80FF_7F01;
        step(0, 1, 0, 32'h0030_0003, 32'h0, 3'd0);
        step(0, 1, 0, 32'h0030_0003, 32'h0, 3'd4);
        step(0, 1, 0, 32'h0030_0002, 32'h0, 3'd1);
        step(0, 0, 0, 32'h0, 32'h0, 3'd2);

        // misaligned capture, sticky error, clear, unmapped read capture
        step(0, 1, 0, 32'h0010_0002, 32'h0, 3'd2);
        step(0, 1, 0, 32'h00F0_0000, 32'h0, 3'd2);
        step(0, 1, 0, 32'h00F0_0004, 32'h0, 3'd2);
        step(0, 0, 1, 32'h7770_0000, 32'h1234, 3'd2);
        step(0, 1, 0, 32'h00F0_0000, 32'h0, 3'd2);
        step(0, 0, 1, 32'h00F0_0000, 32'h0, 3'd2);
        step(0, 1, 0, 32'h7770_0000, 32'h0, 3'd2);
        step(0, 1, 0, 32'h00F0_0000, 32'h0, 3'd2);
        step(0, 1, 0, 32'h00F0_0004, 32'h0, 3'd2);

        // timer: clear, one full millisecond, read back, clear again
        step(0, 0, 1, 32'h00A0_000C, 32'hDEAD, 3'd2);
        repeat (CYC_MS) step(0, 0, 0, 32'h0, 32'h0, 3'd2);
        step(0, 1, 0, 32'h00A0_0000, 32'h0, 3'd2);
        step(0, 1, 0, 32'h00A0_0004, 32'h0, 3'd2);
        step(0, 1, 0, 32'h00A0_0008, 32'h0, 3'd2);
        step(0, 0, 1, 32'h00A0_000C, 32'h0, 3'd0);
        step(0, 1, 0, 32'h00A0_0000, 32'h0, 3'd2);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NCH; i++) chr[i] = $urandom;
            rs = int'($urandom_range(0, 6));
            if (rs < 4)       tg = 12'(rs + 1);
            else if (rs == 4) tg = 12'h00A;
            else if (rs == 5) tg = 12'h00F;
            else              tg = 12'($urandom_range(16, 4095));
            if (rs == 4 || rs == 5) begin
                of = 20'($urandom_range(0, 4) * 4);
                if ($urandom_range(0, 3) == 0) of = of | 20'($urandom_range(0, 3));
            end else begin
                of = 20'($urandom);
            end
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {tg, of}, $urandom, 3'($urandom_range(0, 7)));
        end

        // reset arriving with a load in flight
        step(0, 1, 0, 32'h0010_0001, 32'h0, 3'd1);
        chr[1] = 32'h1234_5678;
        step(0, 1, 0, 32'h0020_0000, 32'h0, 3'd2);
        step(1, 1, 0, 32'h0020_0000, 32'h0, 3'd2);
        step(0, 0, 0, 32'h0, 32'h0, 3'd2);
        step(0, 0, 0, 32'h0, 32'h0, 3'd2);

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clock);
        @(negedge clock);
        if (sbq.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain got=%0d pending want=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
